ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/cpu_types_pkg.sv | 28 ++
 rtl/ram_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the RAM arbiter: bus word, RAM status and arbiter FSM states.
// Also holds the two-way round-robin pick used by the arbiter.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE,
        DWORD0,
        DWORD1,
        IFETCH
    } arb_state_t;

    // Prefer the core that was not granted last; fall back to rr if only it requests.
    function automatic logic rr_pick(input logic [1:0] req, input logic rr);
        return req[~rr] ? ~rr : rr;
    endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Two-core RAM arbiter: two-word data transfers, single-word instruction fetches,
// round-robin between cores and a starvation override for pending fetches.
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned CPUS         = 2,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic      [CPUS-1:0]   iREN,
    input  word_t     [CPUS-1:0]   iaddr,
    input  logic      [CPUS-1:0]   dREN,
    input  logic      [CPUS-1:0]   dWEN,
    input  word_t     [CPUS-1:0]   daddr,
    input  word_t     [CPUS-1:0]   dstore,
    output logic      [CPUS-1:0]   iwait,
    output logic      [CPUS-1:0]   dwait,
    output word_t     [CPUS-1:0]   iload,
    output word_t     [CPUS-1:0]   dload,
    output logic                   ramREN,
    output logic                   ramWEN,
    output word_t                  ramaddr,
    output word_t                  ramstore,
    input  word_t                  ramload,
    input  ramstate_t              ramstate,
    output logic                   owner,
    output logic                   err
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    arb_state_t    state_q, state_d;
    logic          owner_q, owner_d;
    logic          rr_q, rr_d;
    logic [SW-1:0] istarve_q, istarve_d;
    logic          err_q, err_d;

    logic [CPUS-1:0] dreq;
    logic            istarved;
    logic            ifetch_grant;
    logic            pick;

    assign iload = {CPUS{ramload}};
    assign dload = {CPUS{ramload}};
    assign owner = owner_q;
    assign err   = err_q;

    assign dreq     = dREN | dWEN;
    assign istarved = (istarve_q == SW'(STARVE_LIMIT)) && (|iREN);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_d         = rr_q;
        err_d        = 1'b0;
        ifetch_grant = 1'b0;
        pick         = 1'b0;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;
        iwait        = '1;
        dwait        = '1;

        unique case (state_q)
            IDLE: begin
                if (istarved) begin
                    pick         = rr_pick(iREN, rr_q);
                    state_d      = IFETCH;
                    ifetch_grant = 1'b1;
                end else if (|dreq) begin
                    pick    = rr_pick(dreq, rr_q);
                    state_d = DWORD0;
                end else if (|iREN) begin
                    pick         = rr_pick(iREN, rr_q);
                    state_d      = IFETCH;
                    ifetch_grant = 1'b1;
                end
                if (state_d != IDLE) begin
                    owner_d = pick;
                    rr_d    = pick;
                end
            end
            DWORD0, DWORD1: begin
                ramaddr  = daddr[owner_q];
                ramstore = dstore[owner_q];
                ramWEN   = dWEN[owner_q];
                // A write wins over a read raised by the same core.
                ramREN   = dREN[owner_q] & ~dWEN[owner_q];
                if (ramstate == ACCESS) begin
                    dwait[owner_q] = 1'b0;
                    state_d        = (state_q == DWORD0) ? DWORD1 : IDLE;
                end else if (ramstate == ERROR) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            IFETCH: begin
                ramREN  = 1'b1;
                ramaddr = iaddr[owner_q];
                if (ramstate == ACCESS) begin
                    iwait[owner_q] = 1'b0;
                    state_d        = IDLE;
                end else if (ramstate == ERROR) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        istarve_d = istarve_q;
        if (ifetch_grant) begin
            istarve_d = '0;
        end else if ((|iREN) && (state_q != IFETCH) && (istarve_q != SW'(STARVE_LIMIT))) begin
            istarve_d = istarve_q + SW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            rr_q      <= 1'b0;
            istarve_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            istarve_q <= istarve_d;
            err_q     <= err_d;
        end
    end

endmodule
